// File: rtl/text_mode_gen_pkg.sv
// Shared definitions for the text-mode display engine: palette, pipeline depth
// and the field layout of a screen-RAM cell word.
package text_mode_pkg;

    localparam int PIPE_LAT = 4;

    localparam int CHAR_LSB = 0;
    localparam int ATTR_LSB = 8;
    localparam int FG_LSB   = 0;
    localparam int BG_LSB   = 4;

    // Each channel: bit set gives F/A (bright/normal), clear gives 5/0.
    function automatic logic [11:0] palette(input logic [3:0] irgb);
        logic [3:0] lvl_on;
        logic [3:0] lvl_off;
        lvl_on  = irgb[3] ? 4'hF : 4'hA;
        lvl_off = irgb[3] ? 4'h5 : 4'h0;
        return {irgb[2] ? lvl_on : lvl_off,
                irgb[1] ? lvl_on : lvl_off,
                irgb[0] ? lvl_on : lvl_off};
    endfunction

endpackage

// File: rtl/text_mode_gen_if.sv
// Fetch bus between the text engine and its screen RAM / glyph ROM.
interface text_mode_gen_if #(
    parameter int ADDR_W  = 12,
    parameter int GADDR_W = 12,
    parameter int GLYPH_W = 8
);
    logic [ADDR_W-1:0]  cell_addr;
    logic [15:0]        cell_data;
    logic [GADDR_W-1:0] glyph_addr;
    logic [GLYPH_W-1:0] glyph_data;

    modport master (output cell_addr, glyph_addr, input cell_data, glyph_data);
    modport slave  (input cell_addr, glyph_addr, output cell_data, glyph_data);
endinterface

// File: rtl/text_mode_gen_vga_timing.sv
// Raster counters with raw sync, active-video and wrap strobes.
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          h_wrap,
    output logic          frame_wrap,
    output logic          hs_act,
    output logic          vs_act,
    output logic          de
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    assign h_wrap     = 32'(h_cnt) == H_TOTAL - 1;
    assign frame_wrap = h_wrap && (32'(v_cnt) == V_TOTAL - 1);
    assign hs_act     = (32'(h_cnt) >= H_ACTIVE + H_FP) && (32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC);
    assign vs_act     = (32'(v_cnt) >= V_ACTIVE + V_FP) && (32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC);
    assign de         = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= frame_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/text_mode_gen.sv
// Text-mode display engine: cell tracking, RAM/ROM fetch pipeline and colour.
// Optional blinking underline cursor is built when TEXT_MODE_CURSOR_EN is defined.
module text_mode_gen #(
    parameter int COLS     = 80,
    parameter int ROWS     = 30,
    parameter int GLYPH_W  = 8,
    parameter int GLYPH_H  = 16,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    text_mode_gen_if.master mem,
    input  logic [6:0]      cursor_col,
    input  logic [4:0]      cursor_row,
    input  logic            cursor_on,
    output logic [3:0]      r_o,
    output logic [3:0]      g_o,
    output logic [3:0]      b_o,
    output logic            h_sync_o,
    output logic            v_sync_o,
    output logic            de_o,
    output logic            frame_start_o
);
    import text_mode_pkg::*;

    localparam int HW   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int CA_W = $clog2(COLS * ROWS);
    localparam int SX_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
    localparam int GY_W = $clog2(GLYPH_H);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    if (COLS * GLYPH_W > H_ACTIVE) begin : g_bad_width
        $error("text area wider than active video");
    end
    if (ROWS * GLYPH_H > V_ACTIVE) begin : g_bad_height
        $error("text area taller than active video");
    end
    if (GLYPH_W < 1 || GLYPH_W > 16) begin : g_bad_glyph_w
        $error("GLYPH_W out of range");
    end
    if (GLYPH_H < 2 || (GLYPH_H & (GLYPH_H - 1)) != 0) begin : g_bad_glyph_h
        $error("GLYPH_H must be a power of two");
    end

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, frame_wrap, hs_act, vs_act, de_raw;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .h_wrap(h_wrap), .frame_wrap(frame_wrap),
        .hs_act(hs_act), .vs_act(vs_act), .de(de_raw)
    );

    logic [SX_W-1:0] sub_x;
    logic [GY_W-1:0] sub_y;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;

    // col/row saturate on the last cell; beyond the text area they are masked anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_x <= '0;
            col   <= '0;
            sub_y <= '0;
            row   <= '0;
        end else if (h_wrap) begin
            sub_x <= '0;
            col   <= '0;
            if (frame_wrap) begin
                sub_y <= '0;
                row   <= '0;
            end else if (32'(sub_y) == GLYPH_H - 1) begin
                sub_y <= '0;
                if (32'(row) != ROWS - 1) row <= row + 1'b1;
            end else begin
                sub_y <= sub_y + 1'b1;
            end
        end else if (32'(sub_x) == GLYPH_W - 1) begin
            sub_x <= '0;
            if (32'(col) != COLS - 1) col <= col + 1'b1;
        end else begin
            sub_x <= sub_x + 1'b1;
        end
    end

    logic in_text, cur_hit;
    assign in_text = (32'(h_cnt) < COLS * GLYPH_W) && (32'(v_cnt) < ROWS * GLYPH_H);

`ifdef TEXT_MODE_CURSOR_EN
    logic [4:0] frame_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             frame_cnt <= '0;
        else if (frame_wrap) frame_cnt <= frame_cnt + 5'd1;
    end
    assign cur_hit = cursor_on && (32'(col) == 32'(cursor_col)) && (32'(row) == 32'(cursor_row))
                     && (32'(sub_y) >= GLYPH_H - 2) && !frame_cnt[4];
`else
    logic cursor_unused;
    assign cursor_unused = ^{cursor_col, cursor_row, cursor_on};
    assign cur_hit       = 1'b0;
`endif

    logic [CA_W-1:0]     cell_addr_q;
    logic [GY_W-1:0]     sub_y_d1, sub_y_d2;
    logic [SX_W-1:0]     sub_x_d1, sub_x_d2, sub_x_d3;
    logic [2:0]          txt_d, cur_d;
    logic [7:0]          attr_d3;
    logic [PIPE_LAT-1:0] hs_d, vs_d, de_d, fs_d;
    logic [11:0]         rgb_q, pix_rgb;
    logic [GLYPH_W-1:0]  glyph_bits;

    assign mem.cell_addr  = cell_addr_q;
    assign mem.glyph_addr = {mem.cell_data[CHAR_LSB +: 8], sub_y_d2};

    // Shift the current pixel column up to the MSB so no variable index is needed.
    always_comb begin
        glyph_bits = mem.glyph_data << sub_x_d3;
        pix_rgb    = palette((glyph_bits[GLYPH_W-1] || cur_d[2]) ? attr_d3[FG_LSB +: 4]
                                                                 : attr_d3[BG_LSB +: 4]);
        if (!txt_d[2]) pix_rgb = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cell_addr_q <= '0;
            sub_y_d1    <= '0;
            sub_y_d2    <= '0;
            sub_x_d1    <= '0;
            sub_x_d2    <= '0;
            sub_x_d3    <= '0;
            txt_d       <= '0;
            cur_d       <= '0;
            attr_d3     <= '0;
            hs_d        <= '0;
            vs_d        <= '0;
            de_d        <= '0;
            fs_d        <= '0;
            rgb_q       <= '0;
        end else begin
            cell_addr_q <= in_text ? CA_W'(32'(row) * COLS + 32'(col)) : '0;
            sub_y_d1    <= sub_y;
            sub_y_d2    <= sub_y_d1;
            sub_x_d1    <= sub_x;
            sub_x_d2    <= sub_x_d1;
            sub_x_d3    <= sub_x_d2;
            txt_d       <= {txt_d[1:0], in_text};
            cur_d       <= {cur_d[1:0], cur_hit};
            attr_d3     <= mem.cell_data[ATTR_LSB +: 8];
            hs_d        <= {hs_d[PIPE_LAT-2:0], hs_act};
            vs_d        <= {vs_d[PIPE_LAT-2:0], vs_act};
            de_d        <= {de_d[PIPE_LAT-2:0], de_raw};
            fs_d        <= {fs_d[PIPE_LAT-2:0], (h_cnt == '0) && (v_cnt == '0)};
            rgb_q       <= pix_rgb;
        end
    end

    assign {r_o, g_o, b_o} = rgb_q;
    assign h_sync_o        = hs_d[PIPE_LAT-1] ? SYNC_POL : ~SYNC_POL;
    assign v_sync_o        = vs_d[PIPE_LAT-1] ? SYNC_POL : ~SYNC_POL;
    assign de_o            = de_d[PIPE_LAT-1];
    assign frame_start_o   = fs_d[PIPE_LAT-1];
endmodule

// File: tb/tb_text_mode_gen.sv
// Directed bench for text_mode_gen: default 640x480 timing, a 70-column variant
// and a small-raster instance for frame/vsync/cursor behaviour.
module tb_text_mode_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_bc;
    int   ecnt_a, ecnt_bc;
    int   n_vec = 0;
    int   n_err = 0;

`ifdef TEXT_MODE_CURSOR_EN
    localparam logic [31:0] CUR_RGB = 32'hAAA;
`else
    localparam logic [31:0] CUR_RGB = 32'h000;
`endif

    always @(posedge clk or posedge rst_a)
        if (rst_a) ecnt_a <= 0; else ecnt_a <= ecnt_a + 1;
    always @(posedge clk or posedge rst_bc)
        if (rst_bc) ecnt_bc <= 0; else ecnt_bc <= ecnt_bc + 1;

    text_mode_gen_if #(.ADDR_W(12), .GADDR_W(12), .GLYPH_W(8)) mem_a ();
    text_mode_gen_if #(.ADDR_W(8),  .GADDR_W(12), .GLYPH_W(8)) mem_b ();
    text_mode_gen_if #(.ADDR_W(5),  .GADDR_W(12), .GLYPH_W(8)) mem_c ();

    // Screen RAM / glyph ROM models: one-cycle synchronous reads.
    always @(posedge clk) begin
        mem_a.cell_data  <= (mem_a.cell_addr == 12'd165) ? 16'h1E41 :
                            (mem_a.cell_addr == 12'd37)  ? 16'h4000 : 16'h0000;
        mem_a.glyph_data <= (mem_a.glyph_addr == 12'h410) ? 8'h80 : 8'h00;
        mem_b.cell_data  <= (mem_b.cell_addr == 8'd69) ? 16'h2000 : 16'h0000;
        mem_b.glyph_data <= 8'h00;
        mem_c.cell_data  <= 16'h0700;
        mem_c.glyph_data <= 8'h00;
    end

    logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
    logic hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b, hs_c, vs_c, de_c, fs_c;

    text_mode_gen dut_a (
        .clk(clk), .rst(rst_a), .mem(mem_a),
        .cursor_col(7'd5), .cursor_row(5'd2), .cursor_on(1'b0),
        .r_o(r_a), .g_o(g_a), .b_o(b_a),
        .h_sync_o(hs_a), .v_sync_o(vs_a), .de_o(de_a), .frame_start_o(fs_a)
    );

    text_mode_gen #(
        .COLS(70), .ROWS(2), .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .clk(clk), .rst(rst_bc), .mem(mem_b),
        .cursor_col(7'd0), .cursor_row(5'd0), .cursor_on(1'b0),
        .r_o(r_b), .g_o(g_b), .b_o(b_b),
        .h_sync_o(hs_b), .v_sync_o(vs_b), .de_o(de_b), .frame_start_o(fs_b)
    );

    text_mode_gen #(
        .COLS(4), .ROWS(5),
        .H_ACTIVE(32), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(80), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_c (
        .clk(clk), .rst(rst_bc), .mem(mem_c),
        .cursor_col(7'd3), .cursor_row(5'd4), .cursor_on(1'b1),
        .r_o(r_c), .g_o(g_c), .b_o(b_c),
        .h_sync_o(hs_c), .v_sync_o(vs_c), .de_o(de_c), .frame_start_o(fs_c)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_a(input int n);
        while (ecnt_a < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_bc(input int n);
        while (ecnt_bc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    localparam int PA = 32 * 800 + 40;   // dut_a pixel (40,32)
    localparam int FC = 36 * 83;         // dut_c frame length in clocks

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a  = 1'b0;
        rst_bc = 1'b0;

        fork
            begin : thread_a
                wait_a(300);
                check_val("a_pre_de", 32'(de_a), 1);
                check_val("a_pre_rgb", 32'({r_a, g_a, b_a}), 32'hA00);
                check_val("a_pre_addr", 32'(mem_a.cell_addr), 37);
                rst_a = 1'b1;
                #1;
                check_val("a_rst_de", 32'(de_a), 0);
                check_val("a_rst_rgb", 32'({r_a, g_a, b_a}), 0);
                check_val("a_rst_hs", 32'(hs_a), 1);
                check_val("a_rst_vs", 32'(vs_a), 1);
                check_val("a_rst_fs", 32'(fs_a), 0);
                check_val("a_rst_addr", 32'(mem_a.cell_addr), 0);
                repeat (2) @(posedge clk);
                @(negedge clk);
                rst_a = 1'b0;
                wait_a(3);
                check_val("a_de_e3", 32'(de_a), 0);
                check_val("a_fs_e3", 32'(fs_a), 0);
                wait_a(4);
                check_val("a_de_e4", 32'(de_a), 1);
                check_val("a_fs_e4", 32'(fs_a), 1);
                wait_a(5);
                check_val("a_fs_e5", 32'(fs_a), 0);
                wait_a(4 + 639);
                check_val("a_de_639", 32'(de_a), 1);
                wait_a(4 + 640);
                check_val("a_de_640", 32'(de_a), 0);
                wait_a(4 + 655);
                check_val("a_hs_655", 32'(hs_a), 1);
                wait_a(4 + 656);
                check_val("a_hs_656", 32'(hs_a), 0);
                wait_a(4 + 751);
                check_val("a_hs_751", 32'(hs_a), 0);
                wait_a(4 + 752);
                check_val("a_hs_752", 32'(hs_a), 1);
                wait_a(4 + 800);
                check_val("a_de_line1", 32'(de_a), 1);
                check_val("a_fs_line1", 32'(fs_a), 0);
                check_val("a_vs_line1", 32'(vs_a), 1);
                wait_a(4 + 800 + 656);
                check_val("a_hs_line1", 32'(hs_a), 0);
                wait_a(PA + 1);
                check_val("a_cell_addr", 32'(mem_a.cell_addr), 165);
                wait_a(PA + 2);
                check_val("a_glyph_addr", 32'(mem_a.glyph_addr), 32'h410);
                wait_a(PA + 4);
                check_val("a_px40", 32'({r_a, g_a, b_a}), 32'hFF5);
                wait_a(PA + 5);
                check_val("a_px41", 32'({r_a, g_a, b_a}), 32'h00A);
                wait_a(PA + 11);
                check_val("a_px47", 32'({r_a, g_a, b_a}), 32'h00A);
                wait_a(PA + 12);
                check_val("a_px48", 32'({r_a, g_a, b_a}), 32'h000);
                wait_a(PA + 800 + 4);
                check_val("a_px40_y33", 32'({r_a, g_a, b_a}), 32'h00A);
            end
            begin : thread_b
                wait_bc(560);
                check_val("b_addr_559", 32'(mem_b.cell_addr), 69);
                wait_bc(561);
                check_val("b_addr_560", 32'(mem_b.cell_addr), 0);
                wait_bc(563);
                check_val("b_px559", 32'({r_b, g_b, b_b}), 32'h0A0);
                wait_bc(564);
                check_val("b_px560", 32'({r_b, g_b, b_b}), 0);
                check_val("b_de560", 32'(de_b), 1);
                wait_bc(640);
                check_val("b_addr_639", 32'(mem_b.cell_addr), 0);
                wait_bc(643);
                check_val("b_px639", 32'({r_b, g_b, b_b}), 0);
                check_val("b_de639", 32'(de_b), 1);
            end
            begin : thread_c
                wait_bc(4 + 33);
                check_val("c_hs_33", 32'(hs_c), 0);
                wait_bc(4 + 35);
                check_val("c_hs_35", 32'(hs_c), 1);
                wait_bc(4 + 78 * 36 + 24 - 36);
                check_val("c_px24_77", 32'({r_c, g_c, b_c}), 0);
                wait_bc(4 + 78 * 36 + 24);
                check_val("c_cur_24_78", 32'({r_c, g_c, b_c}), CUR_RGB);
                wait_bc(4 + 79 * 36 + 23);
                check_val("c_px23_79", 32'({r_c, g_c, b_c}), 0);
                wait_bc(4 + 79 * 36 + 31);
                check_val("c_cur_31_79", 32'({r_c, g_c, b_c}), CUR_RGB);
                wait_bc(4 + 80 * 36);
                check_val("c_vs_80", 32'(vs_c), 1);
                wait_bc(4 + 81 * 36);
                check_val("c_vs_81", 32'(vs_c), 0);
                wait_bc(4 + 82 * 36);
                check_val("c_vs_82", 32'(vs_c), 1);
                wait_bc(4 + FC);
                check_val("c_fs_f1", 32'(fs_c), 1);
                wait_bc(4 + FC + 1);
                check_val("c_fs_f1_next", 32'(fs_c), 0);
                wait_bc(4 + 15 * FC + 78 * 36 + 28);
                check_val("c_cur_f15", 32'({r_c, g_c, b_c}), CUR_RGB);
                wait_bc(4 + 16 * FC);
                check_val("c_fs_f16", 32'(fs_c), 1);
                wait_bc(4 + 16 * FC + 78 * 36 + 24);
                check_val("c_cur_f16", 32'({r_c, g_c, b_c}), 0);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
